// File: rtl/fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : fp_addsub_seq
// Description : Parametrised multi-cycle floating-point add/subtract unit
//               with start/busy/done handshake, round-to-nearest-even using
//               guard/round/sticky bits, special-value bypass and status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_addsub_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   op,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W:0]   res,
    output logic                   invalid,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   inexact
);

    localparam int c_W = 1 + EXP_W + MAN_W;
    // Extended mantissa: hidden bit, fraction, guard, round, sticky
    localparam int c_M = MAN_W + 4;
    localparam logic [EXP_W-1:0] c_EMAX = {EXP_W{1'b1}};
    localparam logic [c_W-1:0]   c_QNAN = {1'b0, c_EMAX, 1'b1, {(MAN_W-1){1'b0}}};

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_UNPACK = 3'd1;
    localparam logic [2:0] c_ALIGN  = 3'd2;
    localparam logic [2:0] c_ADD    = 3'd3;
    localparam logic [2:0] c_NORM   = 3'd4;
    localparam logic [2:0] c_ROUND  = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;

    logic [2:0]     r_state;
    logic [c_W-1:0] r_a;
    logic [c_W-1:0] r_b;
    logic           r_op;
    logic           r_sx;
    logic           r_sub;
    logic [EXP_W:0] r_ex;
    logic [c_M-1:0] r_mx;
    logic [c_M-1:0] r_my;

    // Operand fields; b carries its effective sign (sign flipped for subtract)
    logic             w_sa;
    logic             w_sb;
    logic [EXP_W-1:0] w_ea;
    logic [EXP_W-1:0] w_eb;
    logic [MAN_W-1:0] w_fa;
    logic [MAN_W-1:0] w_fb;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_a_inf;
    logic             w_b_inf;
    logic             w_a_nan;
    logic             w_b_nan;

    assign w_sa     = r_a[c_W-1];
    assign w_sb     = r_b[c_W-1] ^ r_op;
    assign w_ea     = r_a[c_W-2:MAN_W];
    assign w_eb     = r_b[c_W-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == c_EMAX) && (w_fa == '0);
    assign w_b_inf  = (w_eb == c_EMAX) && (w_fb == '0);
    assign w_a_nan  = (w_ea == c_EMAX) && (w_fa != '0);
    assign w_b_nan  = (w_eb == c_EMAX) && (w_fb != '0);

    logic           w_sp_hit;
    logic           w_sp_inv;
    logic [c_W-1:0] w_sp_res;

    // Special-value classification; a hit skips the arithmetic pipeline
    always_comb begin
        w_sp_hit = 1'b1;
        w_sp_inv = 1'b0;
        w_sp_res = c_QNAN;
        if (w_a_nan || w_b_nan) begin
            w_sp_inv = 1'b1;
        end else if (w_a_inf && w_b_inf) begin
            if (w_sa != w_sb) begin
                w_sp_inv = 1'b1;
            end else begin
                w_sp_res = {w_sa, c_EMAX, {MAN_W{1'b0}}};
            end
        end else if (w_a_inf) begin
            w_sp_res = {w_sa, c_EMAX, {MAN_W{1'b0}}};
        end else if (w_b_inf) begin
            w_sp_res = {w_sb, c_EMAX, {MAN_W{1'b0}}};
        end else if (w_a_zero && w_b_zero) begin
            w_sp_res = {w_sa & w_sb, {(c_W-1){1'b0}}};
        end else if (w_a_zero) begin
            w_sp_res = {w_sb, r_b[c_W-2:0]};
        end else if (w_b_zero) begin
            w_sp_res = r_a;
        end else begin
            w_sp_hit = 1'b0;
        end
    end

    // Alignment: X is the larger magnitude, Y is shifted right with sticky
    logic             w_a_ge;
    logic [EXP_W-1:0] w_ex;
    logic [EXP_W-1:0] w_ey;
    logic [MAN_W-1:0] w_fx;
    logic [MAN_W-1:0] w_fy;
    logic [EXP_W-1:0] w_d;
    logic [c_M-1:0]   w_my_full;
    logic [c_M-1:0]   w_my_shift;
    logic             w_lost;

    assign w_a_ge     = (r_a[c_W-2:0] >= r_b[c_W-2:0]);
    assign w_ex       = w_a_ge ? w_ea : w_eb;
    assign w_ey       = w_a_ge ? w_eb : w_ea;
    assign w_fx       = w_a_ge ? w_fa : w_fb;
    assign w_fy       = w_a_ge ? w_fb : w_fa;
    assign w_d        = w_ex - w_ey;
    assign w_my_full  = {1'b1, w_fy, 3'b000};
    // Shifts of c_M or more leave nothing but the sticky bit
    assign w_my_shift = w_my_full >> w_d;
    assign w_lost     = |(w_my_full & ~({c_M{1'b1}} << w_d));

    // Magnitude add/subtract with one extra carry bit
    logic [c_M:0] w_sum;
    assign w_sum = r_sub ? ({1'b0, r_mx} - {1'b0, r_my})
                         : ({1'b0, r_mx} + {1'b0, r_my});

    // Round to nearest, ties to even, on the normalised mantissa
    logic             w_inc;
    logic [MAN_W+1:0] w_rnd;
    logic [EXP_W:0]   w_rexp;
    logic [MAN_W-1:0] w_rfrac;
    logic             w_rovf;

    assign w_inc   = r_mx[2] & (r_mx[1] | r_mx[0] | r_mx[3]);
    assign w_rnd   = {1'b0, r_mx[c_M-1:3]} + {{(MAN_W+1){1'b0}}, w_inc};
    assign w_rexp  = r_ex + {{EXP_W{1'b0}}, w_rnd[MAN_W+1]};
    assign w_rfrac = w_rnd[MAN_W+1] ? w_rnd[MAN_W:1] : w_rnd[MAN_W-1:0];
    assign w_rovf  = (w_rexp >= {1'b0, c_EMAX});

    // Control FSM and datapath registers; outputs update only on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 1'b0;
            r_sx      <= 1'b0;
            r_sub     <= 1'b0;
            r_ex      <= '0;
            r_mx      <= '0;
            r_my      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res       <= '0;
            invalid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_op    <= op;
                        busy    <= 1'b1;
                        r_state <= c_UNPACK;
                    end
                end
                c_UNPACK: begin
                    if (w_sp_hit) begin
                        res       <= w_sp_res;
                        invalid   <= w_sp_inv;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        inexact   <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_state <= c_ALIGN;
                    end
                end
                c_ALIGN: begin
                    r_sx    <= w_a_ge ? w_sa : w_sb;
                    r_sub   <= w_sa ^ w_sb;
                    r_ex    <= {1'b0, w_ex};
                    r_mx    <= {1'b1, w_fx, 3'b000};
                    r_my    <= {w_my_shift[c_M-1:1], w_my_shift[0] | w_lost};
                    r_state <= c_ADD;
                end
                c_ADD: begin
                    // Carry and already-normalised sums skip the NORM loop
                    if (w_sum[c_M]) begin
                        r_mx    <= {w_sum[c_M:2], w_sum[1] | w_sum[0]};
                        r_ex    <= r_ex + 1'b1;
                        r_state <= c_ROUND;
                    end else if (w_sum == '0) begin
                        r_mx    <= '0;
                        r_ex    <= '0;
                        r_sx    <= 1'b0;
                        r_state <= c_ROUND;
                    end else begin
                        r_mx    <= w_sum[c_M-1:0];
                        r_state <= w_sum[c_M-1] ? c_ROUND : c_NORM;
                    end
                end
                c_NORM: begin
                    // One left shift per cycle; exponent would hit zero -> flush
                    if (r_ex[EXP_W:1] == '0) begin
                        res       <= {r_sx, {(c_W-1){1'b0}}};
                        invalid   <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b1;
                        inexact   <= 1'b1;
                        done      <= 1'b1;
                        r_state   <= c_DONE;
                    end else begin
                        r_mx <= r_mx << 1;
                        r_ex <= r_ex - 1'b1;
                        if (r_mx[c_M-2]) begin
                            r_state <= c_ROUND;
                        end
                    end
                end
                c_ROUND: begin
                    invalid   <= 1'b0;
                    underflow <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= c_DONE;
                    if (!r_mx[c_M-1]) begin
                        res      <= '0;
                        overflow <= 1'b0;
                        inexact  <= 1'b0;
                    end else if (w_rovf) begin
                        res      <= {r_sx, c_EMAX, {MAN_W{1'b0}}};
                        overflow <= 1'b1;
                        inexact  <= 1'b1;
                    end else begin
                        res      <= {r_sx, w_rexp[EXP_W-1:0], w_rfrac};
                        overflow <= 1'b0;
                        inexact  <= |r_mx[2:0];
                    end
                end
                c_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_addsub_seq
// Description : Self-checking bench for fp_addsub_seq (single and half format)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] res;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        inexact;
    logic [3:0]  flags;

    logic        h_start;
    logic        h_op;
    logic [15:0] h_a;
    logic [15:0] h_b;
    logic        h_busy;
    logic        h_done;
    logic [15:0] h_res;
    logic        h_invalid;
    logic        h_overflow;
    logic        h_underflow;
    logic        h_inexact;

    assign flags = {invalid, overflow, underflow, inexact};

    fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res(res), .invalid(invalid),
        .overflow(overflow), .underflow(underflow), .inexact(inexact)
    );

    fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk(clk), .rst(rst), .start(h_start), .op(h_op), .a(h_a), .b(h_b),
        .busy(h_busy), .done(h_done), .res(h_res), .invalid(h_invalid),
        .overflow(h_overflow), .underflow(h_underflow), .inexact(h_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  flags;  // {invalid, overflow, underflow, inexact}
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flags;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, expv);
        end
    endtask

    task automatic timeout_fail(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: no done within cycle budget", nm);
    endtask

    // Scoreboard: each done pulse is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got res %h, expected no done", res);
            end else begin
                e = sb_q.pop_front();
                chk("res", res, e.res);
                chk("flags", 32'(flags), 32'(e.flags));
            end
        end
    end

    task automatic do_op(input vec_t v);
        int n;
        int nb;
        exp_t e;
        e.res   = v.res;
        e.flags = v.flags;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = v.op; a = v.a; b = v.b;
        @(negedge clk);
        start = 1'b0;
        n  = 1;
        nb = 0;
        while (!done && n < 100) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        if (!done) begin
            timeout_fail(v.name);
            sb_q.delete();
        end else begin
            if (busy) nb++;
            chk($sformatf("%s_latency", v.name), 32'(n), 32'(v.lat));
            chk($sformatf("%s_busy_cycles", v.name), 32'(nb), 32'(v.lat));
            @(negedge clk);
            chk($sformatf("%s_done_width", v.name), 32'(done), 32'd0);
            chk($sformatf("%s_busy_after", v.name), 32'(busy), 32'd0);
        end
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) timeout_fail(nm);
    endtask

    task automatic run_h(input string nm, input logic o, input logic [15:0] aa,
                         input logic [15:0] bb, input logic [15:0] er,
                         input logic [3:0] ef, input int en);
        int n;
        @(negedge clk);
        h_start = 1'b1; h_op = o; h_a = aa; h_b = bb;
        @(negedge clk);
        h_start = 1'b0;
        n = 1;
        while (!h_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!h_done) begin
            timeout_fail(nm);
        end else begin
            chk($sformatf("%s_res", nm), 32'(h_res), 32'(er));
            chk($sformatf("%s_flags", nm),
                32'({h_invalid, h_overflow, h_underflow, h_inexact}), 32'(ef));
            chk($sformatf("%s_latency", nm), 32'(n), 32'(en));
        end
    endtask

    initial begin
        int d0;
        exp_t e;

        vecs.push_back('{"add_1_2",       1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'b0000, 5});
        vecs.push_back('{"cancel_l23",    1'b1, 32'h3F800001, 32'h3F800000, 32'h34000000, 4'b0000, 28});
        vecs.push_back('{"sub_equal",     1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'b0000, 5});
        vecs.push_back('{"tie_even",      1'b0, 32'h4B800000, 32'h3F800000, 32'h4B800000, 4'b0001, 5});
        vecs.push_back('{"round_up",      1'b0, 32'h4B800000, 32'h40400000, 32'h4B800002, 4'b0001, 5});
        vecs.push_back('{"overflow",      1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'b0101, 5});
        vecs.push_back('{"inf_minus_inf", 1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{"nan_in",        1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 2});
        vecs.push_back('{"b_zero",        1'b1, 32'h3F800000, 32'h00000000, 32'h3F800000, 4'b0000, 2});
        vecs.push_back('{"both_zero_neg", 1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 4'b0000, 2});
        vecs.push_back('{"minus_inf",     1'b1, 32'h3F800000, 32'h7F800000, 32'hFF800000, 4'b0000, 2});
        vecs.push_back('{"swap_neg",      1'b1, 32'h3F800000, 32'h40000000, 32'hBF800000, 4'b0000, 6});
        vecs.push_back('{"norm_l2",       1'b1, 32'h3F800000, 32'h3F400000, 32'h3E800000, 4'b0000, 7});
        vecs.push_back('{"round_lsb_odd", 1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'b0001, 5});
        vecs.push_back('{"round_carry",   1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 4'b0001, 5});
        vecs.push_back('{"underflow",     1'b1, 32'h80800001, 32'h80800000, 32'h80000000, 4'b0011, 5});

        rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
        h_start = 1'b0; h_op = 1'b0; h_a = '0; h_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_res", res, 32'd0);
        chk("reset_flags", 32'(flags), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i]);
        end

        // Start while busy must be ignored and must not alter the result
        d0 = n_done;
        e.res = 32'h40400000; e.flags = 4'b0000;
        sb_q.push_back(e);
        @(negedge clk);
        start = 1'b1; op = 1'b0; a = 32'h3F800000; b = 32'h40000000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'h7F800000; b = 32'h7F800000;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_ignore");
        // Start raised during the DONE cycle must not be accepted
        start = 1'b1; a = 32'h3F800000; b = 32'h3F800000; op = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("busy_ignore_done_count", 32'(n_done - d0), 32'd1);
        chk("busy_ignore_res_held", res, 32'h40400000);

        // Reset in the middle of the NORM loop aborts the operation
        d0 = n_done;
        @(negedge clk);
        start = 1'b1; op = 1'b1; a = 32'h3F800001; b = 32'h3F800000;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_res", res, 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (40) @(negedge clk);
        chk("abort_no_done", 32'(n_done - d0), 32'd0);
        do_op(vecs[0]);

        // Half-width configuration
        run_h("h_add_1_2", 1'b0, 16'h3C00, 16'h4000, 16'h4200, 4'b0000, 5);
        run_h("h_denorm",  1'b0, 16'h0001, 16'h3C00, 16'h3C00, 4'b0000, 2);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fp_addsub_seq.md
Name: fp_addsub_seq

Overview:
Parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit. It is the successor to the existing fixed single-precision adder. It adds configurable exponent and mantissa widths, a start/busy/done handshake, synchronous reset, round-to-nearest-even with guard/round/sticky bits, special-value handling and status flags. It sits beside the ALU as a shared FP datapath and is driven by the controller one operation at a time.

Parameters:
EXP_W, 8, exponent field width (>=4)
MAN_W, 23, stored fraction width (>=4); word width W = 1+EXP_W+MAN_W

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
op  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  W  operand A; sampled with start
b  input  W  operand B; sampled with start
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; res and flags are valid from this cycle onward
res  output  W  result; held until the next accepted start
invalid  output  1  inf-inf or NaN operand
overflow  output  1  result rounded to infinity
underflow  output  1  nonzero result flushed to zero
inexact  output  1  any discarded nonzero bits (GRS != 0), or overflow/underflow

Behaviour:
- Reset: state=IDLE; busy, done, res, all flags = 0. Reset asserted in any state aborts the operation: no done pulse, and busy=0 on the next cycle.
- Operands are registered on the accepted start. start while busy is ignored.
- FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM (self-loop) -> ROUND -> DONE -> IDLE. DONE lasts one cycle. From DONE, a start given in the same cycle is not accepted; it is accepted in IDLE.
- UNPACK:
  - Effective sign of b = b.sign ^ op.
  - Exp=0 inputs are treated as ±0 (denormals are flushed, sign kept).
  - Special cases go directly to DONE:
    - Any NaN -> canonical qNaN (sign 0, exp all ones, fraction MSB 1, rest 0), invalid=1.
    - inf + (-inf) -> qNaN, invalid=1.
    - Any single inf -> that inf.
    - Both operands zero -> zero; sign is negative only when both effective signs are negative.
    - Exactly one operand zero -> the other operand, unchanged, flags 0.
- ALIGN:
  - Swap operands so that X has the larger magnitude.
  - Extended mantissas are {1, frac, G, R, S} (MAN_W+4 bits).
  - Right-shift Y by the exponent difference in one cycle. Shifted-out bits OR into S. A difference > MAN_W+3 reduces Y to S only.
- ADD: effective add or subtract of the magnitudes, one extra carry bit. Result sign = sign of X.
- NORM:
  - Carry set: shift right by 1 (shifted-out bit ORs into S), exp+1, then go to ROUND.
  - Leading 1 below the hidden position: shift left by 1 per cycle, exp-1 per cycle, stay in NORM.
  - Exp reaching 0 before normalisation: flush to zero with sign, underflow=1, inexact=1, go to DONE.
  - Exact zero sum: +0, go to ROUND with no shifts.
- ROUND:
  - Round to nearest, ties to even: increment when G & (R|S|LSB).
  - Mantissa overflow after rounding: shift right by 1 and exp+1 in the same cycle.
  - exp >= all ones -> ±inf, overflow=1, inexact=1.
  - res is registered on entry to DONE.
- Latency N = number of rising edges from the start-sampling edge to the done-high cycle:
  - N = 2 for the UNPACK bypass.
  - N = 5 + L on the normal path, where L = number of NORM left shifts (0..MAN_W+3).
  - A carry right-shift adds no cycle.
  - Maximum N = MAN_W+8.

Test Plan:
- a=0x3F800000, b=0x40000000, op=0 -> res=0x40400000, flags 0, done N=5, busy high for 5 cycles, done width 1.
- a=0x3F800001, b=0x3F800000, op=1 -> res=0x34000000, exact, N=28 (L=23). Second case: a=0x3F800000, b=0x3F800000, op=1 -> res=0x00000000, N=5.
- a=0x4B800000, b=0x3F800000, op=0 (tie) -> res=0x4B800000, inexact=1. Second case: a=0x4B800000, b=0x40400000, op=0 -> res=0x4B800002, inexact=1.
- a=0x7F7FFFFF, b=0x7F7FFFFF, op=0 -> res=0x7F800000, overflow=1, inexact=1. Second case: a=0x7F800000, b=0x7F800000, op=1 -> res=0x7FC00000, invalid=1, N=2.
- Pulse start again while busy with different operands -> ignored; the first result is unchanged. Assert rst for 1 cycle while in NORM (cancellation case) -> no done, busy=0 and res=0 after the reset edge, next start works normally.
- Parameter sweep EXP_W=5, MAN_W=10: a=0x3C00 (1.0), b=0x4000 (2.0), op=0 -> res=0x4200. a=0x0001 (denormal), b=0x3C00 -> res=0x3C00, flags 0.
